// File: rtl/butterfly_seq_ctrl.sv
// Load/compute sequencer for the two-operand datapath: pulls operand pairs, strobes the
// datapath once per pair and offers each captured result downstream.
module butterfly_seq_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  num_ops_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              dp_load_o,
   output logic              dp_compute_o,
   output logic [DATA_W-1:0] dp_a_o,
   output logic [DATA_W-1:0] dp_b_o,
   input  logic [DATA_W-1:0] dp_result_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [DATA_W-1:0] res_data_o,
   output logic              res_last_o
);

   typedef enum logic [2:0] {
      StIdle,
      StAccept,
      StLoad,
      StCompute,
      StCapture,
      StOutput
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [DATA_W-1:0] dp_a_q, dp_a_d;
   logic [DATA_W-1:0] dp_b_q, dp_b_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         res_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         dp_a_q      <= dp_a_d;
         dp_b_q      <= dp_b_d;
         res_data_q  <= res_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      dp_a_d      = dp_a_q;
      dp_b_d      = dp_b_q;
      res_data_d  = res_data_q;
      done_d      = 1'b0;
      // Abort outranks every handshake; the in-flight op is dropped without a done pulse.
      if (abort_i && (state_q != StIdle)) begin
         state_d     = StIdle;
         remaining_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (num_ops_i != '0) begin
                     remaining_d = num_ops_i;
                     state_d     = StAccept;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            StAccept: begin
               if (op_valid_i) begin
                  dp_a_d  = op_a_i;
                  dp_b_d  = op_b_i;
                  state_d = StLoad;
               end
            end
            StLoad:    state_d = StCompute;
            StCompute: state_d = StCapture;
            StCapture: begin
               res_data_d = dp_result_i;
               state_d    = StOutput;
            end
            StOutput: begin
               if (res_ready_i) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StAccept;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy_o       = (state_q != StIdle);
      op_ready_o   = (state_q == StAccept);
      dp_load_o    = (state_q == StLoad);
      dp_compute_o = (state_q == StCompute);
      res_valid_o  = (state_q == StOutput);
      res_last_o   = (state_q == StOutput) && (remaining_q == CNT_W'(1));
      done_o       = done_q;
      dp_a_o       = dp_a_q;
      dp_b_o       = dp_b_q;
      res_data_o   = res_data_q;
   end

endmodule

// File: tb/tb_butterfly_seq_ctrl.sv
// Directed bench for butterfly_seq_ctrl with an adder datapath model and a result scoreboard.
module tb_butterfly_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, abort, op_valid, res_ready;
   logic [7:0] num_ops, op_a, op_b, dp_result;
   logic       busy, done, op_ready, dp_load, dp_compute, res_valid, res_last;
   logic [7:0] dp_a, dp_b, res_data;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int popped = 0;
   logic [8:0] sb[$];
   logic [7:0] ba[3];
   logic [7:0] bb[3];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;

   always #5 clk = ~clk;

   butterfly_seq_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start_i(start), .num_ops_i(num_ops), .abort_i(abort),
      .busy_o(busy), .done_o(done), .op_valid_i(op_valid), .op_ready_o(op_ready),
      .op_a_i(op_a), .op_b_i(op_b), .dp_load_o(dp_load), .dp_compute_o(dp_compute),
      .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_result_i(dp_result), .res_valid_o(res_valid),
      .res_ready_i(res_ready), .res_data_o(res_data), .res_last_o(res_last)
   );

   // External datapath: registered sum, valid the cycle after compute.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dp_result <= 8'h00;
      else if (dp_compute) dp_result <= dp_a + dp_b;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         logic [8:0] e;
         if (done) done_cnt++;
         if (prev_stall) begin
            check("hold_data", 32'(res_data), 32'(prev_data));
            check("hold_valid", 32'(res_valid), 1);
         end
         if (res_valid && res_ready && !abort) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0h expected none", res_data);
            end else begin
               e = sb.pop_front();
               check("res_data", 32'(res_data), 32'(e[7:0]));
               check("res_last", 32'(res_last), 32'(e[8]));
               popped++;
            end
         end
         prev_stall = res_valid && !res_ready && !abort;
         prev_data  = res_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_op_ready"}, 32'(op_ready), 0);
      check({tag, "_dp_load"}, 32'(dp_load), 0);
      check({tag, "_dp_compute"}, 32'(dp_compute), 0);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_res_last"}, 32'(res_last), 0);
      check({tag, "_dp_a"}, 32'(dp_a), 0);
      check({tag, "_dp_b"}, 32'(dp_b), 0);
      check({tag, "_res_data"}, 32'(res_data), 0);
   endtask

   function automatic logic probe(input int w);
      case (w)
         0:       return dp_compute;
         1:       return res_valid;
         default: return dp_load;
      endcase
   endfunction

   task automatic wait_probe(input string name, input int w);
      int c = 0;
      while (!probe(w) && c < 20) begin
         tick();
         c++;
      end
      check({name, "_seen"}, 32'(probe(w)), 1);
   endtask

   task automatic run_batch(input int n, input bit stall_en);
      int  idx = 0;
      int  d0 = done_cnt;
      int  p0 = popped;
      int  stall_cnt = 0;
      bit  fin = 1'b0;
      bit  hs;
      start = 1'b1; num_ops = 8'(n); op_valid = 1'b0; res_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
         op_valid = (idx < n) ? 1'($urandom_range(0, 1)) : 1'b0;
         op_a = ba[(idx < n) ? idx : 0];
         op_b = bb[(idx < n) ? idx : 0];
         if (stall_en && (popped - p0 == 1) && stall_cnt < 4 && res_valid) begin
            res_ready = 1'b0;
            stall_cnt++;
         end else begin
            res_ready = 1'b1;
         end
         @(negedge clk);
         hs = op_valid && op_ready;
         @(posedge clk);
         #1;
         if (hs) idx++;
         if (done) fin = 1'b1;
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      check("batch_finished", 32'(fin), 1);
      check("ops_taken", idx, n);
      tick();
      check("done_once", done_cnt - d0, 1);
      check("done_dropped", 32'(done), 0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
      num_ops = 8'h00; op_a = 8'h00; op_b = 8'h00;
      #12;
      check_idle("reset");
      #10 rst = 1'b0;
      tick();

      // Single op with cycle-exact strobe timing.
      start = 1'b1; num_ops = 8'd1; op_valid = 1'b1; op_a = 8'h12; op_b = 8'h34;
      res_ready = 1'b1;
      sb.push_back(9'h146);
      tick();
      start = 1'b0;
      check("t1_op_ready", 32'(op_ready), 1);
      check("t1_busy", 32'(busy), 1);
      tick();
      op_valid = 1'b0;
      check("t1_load", 32'(dp_load), 1);
      check("t1_load_nocomp", 32'(dp_compute), 0);
      check("t1_dp_a", 32'(dp_a), 32'h12);
      check("t1_dp_b", 32'(dp_b), 32'h34);
      tick();
      check("t1_compute", 32'(dp_compute), 1);
      check("t1_comp_noload", 32'(dp_load), 0);
      tick();
      check("t1_capture_novalid", 32'(res_valid), 0);
      tick();
      check("t1_res_valid", 32'(res_valid), 1);
      tick();
      check("t1_done", 32'(done), 1);
      check("t1_idle", 32'(busy), 0);
      tick();
      check("t1_done_pulse", 32'(done), 0);

      // Wrap is the datapath's; controller passes it through.
      ba[0] = 8'hF0; bb[0] = 8'h20;
      sb.push_back(9'h110);
      run_batch(1, 1'b0);

      // Batch of 3 with random op_valid and a 4-cycle stall on op 2.
      ba[0] = 8'h01; bb[0] = 8'h02;
      ba[1] = 8'hFF; bb[1] = 8'h01;
      ba[2] = 8'h80; bb[2] = 8'h7F;
      sb.push_back(9'h003);
      sb.push_back(9'h000);
      sb.push_back(9'h1FF);
      run_batch(3, 1'b1);

      // Empty batch.
      d0 = done_cnt;
      start = 1'b1; num_ops = 8'd0;
      tick();
      start = 1'b0;
      check("zero_done", 32'(done), 1);
      check("zero_busy", 32'(busy), 0);
      check("zero_noload", 32'(dp_load), 0);
      tick();
      check("zero_done_pulse", 32'(done), 0);
      check("zero_busy2", 32'(busy), 0);
      check("zero_done_cnt", done_cnt - d0, 1);

      // Abort in COMPUTE.
      d0 = done_cnt;
      start = 1'b1; num_ops = 8'd2; op_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
      tick();
      start = 1'b0;
      wait_probe("abort_c", 0);
      op_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_c_busy", 32'(busy), 0);
      check("abort_c_res_valid", 32'(res_valid), 0);
      check("abort_c_compute", 32'(dp_compute), 0);
      check("abort_c_op_ready", 32'(op_ready), 0);
      repeat (6) tick();
      check("abort_c_nodone", done_cnt - d0, 0);
      check("abort_c_idle", 32'(busy), 0);

      // Abort in OUTPUT with res_ready high in the same cycle.
      start = 1'b1; num_ops = 8'd2; op_valid = 1'b1; op_a = 8'h05; op_b = 8'h06;
      res_ready = 1'b1;
      tick();
      start = 1'b0;
      wait_probe("abort_o", 1);
      op_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_o_busy", 32'(busy), 0);
      check("abort_o_res_valid", 32'(res_valid), 0);
      check("abort_o_done", 32'(done), 0);
      tick();
      check("abort_o_nodone", done_cnt - d0, 0);

      ba[0] = 8'h05; bb[0] = 8'h06;
      sb.push_back(9'h10B);
      run_batch(1, 1'b0);

      // Asynchronous reset in LOAD.
      start = 1'b1; num_ops = 8'd2; op_valid = 1'b1; op_a = 8'h33; op_b = 8'h44;
      tick();
      start = 1'b0;
      wait_probe("rst_mid", 2);
      op_valid = 1'b0;
      #3 rst = 1'b1;
      #1 check_idle("rst_mid");
      start = 1'b1; num_ops = 8'd1;
      tick();
      tick();
      check("rst_hold_busy", 32'(busy), 0);
      #2 rst = 1'b0;
      start = 1'b0;
      tick();
      check("rst_release_busy", 32'(busy), 0);
      ba[0] = 8'h33; bb[0] = 8'h44;
      sb.push_back(9'h177);
      run_batch(1, 1'b0);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
